// File: rtl/conv_para_scale_ctrl_if.sv
// Output-tile valid/ready channel between the conv sequencer and its downstream consumer.
interface conv_para_scale_ctrl_if #(
    parameter int unsigned TILE_WIDTH = 144
);
    logic                  out_valid;
    logic                  out_ready;
    logic [TILE_WIDTH-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/conv_para_scale_ctrl.sv
// Sequencer for the ConvParaScaleFloat16 datapath: clear, snake-order kernel walk, drain, tile handoff.
// Optional cycle/stall counters are enabled by defining CONV_CTRL_PERF_EN.
module conv_para_scale_ctrl #(
    parameter int unsigned PARA_X            = 3,
    parameter int unsigned PARA_Y            = 3,
    parameter int unsigned DATA_WIDTH        = 16,
    parameter int unsigned KERNEL_SIZE_WIDTH = 4,
    parameter int unsigned KERNEL_MAX        = 5,
    parameter int unsigned DRAIN_TIMEOUT     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [KERNEL_SIZE_WIDTH-1:0]          kernel_size,
    output logic                                  busy,
    output logic                                  cfg_err,
    output logic                                  timeout_err,
    output logic                                  conv_rst,
    output logic [2*KERNEL_SIZE_WIDTH-1:0]        weight_addr,
    output logic [1:0]                            move_code,
    output logic [KERNEL_SIZE_WIDTH-1:0]          kx,
    output logic [KERNEL_SIZE_WIDTH-1:0]          ky,
    input  logic                                  conv_result_ready,
    input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]   conv_result,
`ifdef CONV_CTRL_PERF_EN
    output logic [31:0]                           perf_cycles,
    output logic [31:0]                           perf_stall,
`endif
    conv_para_scale_ctrl_if.master                out_bus
);

    localparam int unsigned KW = KERNEL_SIZE_WIDTH;
    localparam int unsigned AW = 2 * KERNEL_SIZE_WIDTH;
    localparam int unsigned CW = $clog2(DRAIN_TIMEOUT) + 1;

    localparam logic [1:0] MOVE_FULL  = 2'd0;
    localparam logic [1:0] MOVE_RIGHT = 2'd1;
    localparam logic [1:0] MOVE_LEFT  = 2'd2;
    localparam logic [1:0] MOVE_DOWN  = 2'd3;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, HOLD} state_t;

    state_t        state;
    logic [KW-1:0] k_reg;
    logic [CW-1:0] drain_cnt;

    logic          k_legal;
    logic          row_end;
    logic          last_step;
    logic [KW-1:0] nxt_kx;
    logic [KW-1:0] nxt_ky;
    logic [1:0]    nxt_move;

    // Snake walk: even rows step right, odd rows step left, row ends step down.
    always_comb begin
        k_legal   = (kernel_size != '0) && (kernel_size <= KW'(KERNEL_MAX));
        row_end   = ky[0] ? (kx == '0) : (kx == k_reg - KW'(1));
        last_step = row_end && (ky == k_reg - KW'(1));
        nxt_kx    = kx;
        nxt_ky    = ky;
        nxt_move  = MOVE_DOWN;
        if (row_end) begin
            nxt_ky = ky + KW'(1);
        end else if (ky[0]) begin
            nxt_kx   = kx - KW'(1);
            nxt_move = MOVE_LEFT;
        end else begin
            nxt_kx   = kx + KW'(1);
            nxt_move = MOVE_RIGHT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            k_reg             <= '0;
            drain_cnt         <= '0;
            busy              <= 1'b0;
            cfg_err           <= 1'b0;
            timeout_err       <= 1'b0;
            conv_rst          <= 1'b0;
            weight_addr       <= '0;
            move_code         <= MOVE_FULL;
            kx                <= '0;
            ky                <= '0;
            out_bus.out_valid <= 1'b0;
            out_bus.out_data  <= '0;
        end else begin
            cfg_err     <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    conv_rst <= 1'b1;
                    if (start) begin
                        if (k_legal) begin
                            k_reg    <= kernel_size;
                            busy     <= 1'b1;
                            conv_rst <= 1'b0;
                            state    <= CLEAR;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    conv_rst    <= 1'b1;
                    kx          <= '0;
                    ky          <= '0;
                    move_code   <= MOVE_FULL;
                    weight_addr <= '0;
                    state       <= FEED;
                end
                FEED: begin
                    if (last_step) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        kx          <= nxt_kx;
                        ky          <= nxt_ky;
                        move_code   <= nxt_move;
                        weight_addr <= AW'(nxt_ky) * AW'(k_reg) + AW'(nxt_kx);
                    end
                end
                DRAIN: begin
                    if (conv_result_ready) begin
                        out_bus.out_data  <= conv_result;
                        out_bus.out_valid <= 1'b1;
                        state             <= HOLD;
                    end else if (drain_cnt == CW'(DRAIN_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (out_bus.out_ready) begin
                        out_bus.out_valid <= 1'b0;
                        busy              <= 1'b0;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV_CTRL_PERF_EN
    // Saturating busy-cycle and downstream-stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && (perf_cycles != '1)) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if ((state == HOLD) && !out_bus.out_ready && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_para_scale_ctrl.sv
// Self-checking bench for conv_para_scale_ctrl: directed vector table, hand sequences and random tiles.
module tb_conv_para_scale_ctrl;
    localparam int unsigned KW   = 4;
    localparam int unsigned AW   = 8;
    localparam int unsigned TW   = 3 * 3 * 16;
    localparam int unsigned KMAX = 5;
    localparam int unsigned DTO  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] kernel_size;
    logic          busy;
    logic          cfg_err;
    logic          timeout_err;
    logic          conv_rst;
    logic [AW-1:0] weight_addr;
    logic [1:0]    move_code;
    logic [KW-1:0] kx;
    logic [KW-1:0] ky;
    logic          conv_result_ready;
    logic [TW-1:0] conv_result;

    int n_cmp = 0;
    int n_err = 0;

    int addr3[9] = '{0, 1, 2, 5, 4, 3, 6, 7, 8};
    int move3[9] = '{0, 1, 1, 3, 2, 2, 3, 1, 1};

    typedef struct {
        int k;
        int dw;   // DRAIN cycles with ready low before the ready pulse
        int hw;   // HOLD cycles with out_ready low
        bit cfg;  // expected cfg_err rejection
        bit to;   // expected drain timeout
        bit rh;   // reset while the tile is held
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    conv_para_scale_ctrl_if #(.TILE_WIDTH(TW)) bus ();

    conv_para_scale_ctrl #(
        .PARA_X(3), .PARA_Y(3), .DATA_WIDTH(16),
        .KERNEL_SIZE_WIDTH(KW), .KERNEL_MAX(KMAX), .DRAIN_TIMEOUT(DTO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .kernel_size(kernel_size),
        .busy(busy),
        .cfg_err(cfg_err),
        .timeout_err(timeout_err),
        .conv_rst(conv_rst),
        .weight_addr(weight_addr),
        .move_code(move_code),
        .kx(kx),
        .ky(ky),
        .conv_result_ready(conv_result_ready),
        .conv_result(conv_result),
        .out_bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_tile(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_busy"},    32'(busy),          32'(0));
        chk({nm, "_cfg"},     32'(cfg_err),       32'(0));
        chk({nm, "_to"},      32'(timeout_err),   32'(0));
        chk({nm, "_crst"},    32'(conv_rst),      32'(0));
        chk({nm, "_addr"},    32'(weight_addr),   32'(0));
        chk({nm, "_move"},    32'(move_code),     32'(0));
        chk({nm, "_kx"},      32'(kx),            32'(0));
        chk({nm, "_ky"},      32'(ky),            32'(0));
        chk({nm, "_valid"},   32'(bus.out_valid), 32'(0));
        chk_tile({nm, "_data"}, bus.out_data, '0);
    endtask

    function automatic logic [TW-1:0] rand_tile();
        return TW'({$urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    // Full transaction starting in an IDLE cycle; expected walk derived from step index arithmetic.
    task automatic run_tile(input int k, input int dw, input int hw,
                            input bit exp_cfg, input bit exp_to, input bit rst_hold);
        logic [TW-1:0] tile;
        int ky_m, pos, kx_m, mv_m;
        tile = '0;
        start = 1'b1;
        kernel_size = KW'(k);
        step();
        start = 1'b0;
        kernel_size = KW'($urandom_range(0, 15));
        if (exp_cfg) begin
            chk("cfg_err_pulse", 32'(cfg_err), 32'(1));
            chk("rej_busy", 32'(busy), 32'(0));
            chk("rej_conv_rst", 32'(conv_rst), 32'(1));
            step();
            chk("cfg_err_clear", 32'(cfg_err), 32'(0));
            chk("rej_busy2", 32'(busy), 32'(0));
            return;
        end
        chk("accept_no_cfg", 32'(cfg_err), 32'(0));
        chk("clear_conv_rst", 32'(conv_rst), 32'(0));
        chk("clear_busy", 32'(busy), 32'(1));
        conv_result_ready = 1'($urandom_range(0, 1));
        step();
        for (int s = 0; s < k * k; s++) begin
            ky_m = s / k;
            pos  = s % k;
            kx_m = (ky_m % 2 == 0) ? pos : k - 1 - pos;
            mv_m = (s == 0) ? 0 : (pos == 0) ? 3 : (ky_m % 2 == 0) ? 1 : 2;
            chk("feed_kx", 32'(kx), 32'(kx_m));
            chk("feed_ky", 32'(ky), 32'(ky_m));
            chk("feed_addr", 32'(weight_addr), 32'(ky_m * k + kx_m));
            chk("feed_move", 32'(move_code), 32'(mv_m));
            chk("feed_conv_rst", 32'(conv_rst), 32'(1));
            chk("feed_busy", 32'(busy), 32'(1));
            if (k == 3) begin
                chk("k3_addr_const", 32'(weight_addr), 32'(addr3[s]));
                chk("k3_move_const", 32'(move_code), 32'(move3[s]));
            end
            conv_result_ready = 1'($urandom_range(0, 1));
            kernel_size = KW'($urandom_range(0, 15));
            step();
        end
        for (int d = 0; d < int'(DTO); d++) begin
            chk("drain_busy", 32'(busy), 32'(1));
            chk("drain_valid", 32'(bus.out_valid), 32'(0));
            chk("drain_to", 32'(timeout_err), 32'(0));
            tile = rand_tile();
            conv_result = tile;
            conv_result_ready = (d == dw);
            step();
            if (d == dw) break;
        end
        conv_result_ready = 1'b0;
        if (exp_to) begin
            chk("timeout_pulse", 32'(timeout_err), 32'(1));
            chk("timeout_busy", 32'(busy), 32'(0));
            chk("timeout_valid", 32'(bus.out_valid), 32'(0));
            step();
            chk("timeout_once", 32'(timeout_err), 32'(0));
            chk("timeout_valid2", 32'(bus.out_valid), 32'(0));
            return;
        end
        chk("capture_valid", 32'(bus.out_valid), 32'(1));
        chk_tile("capture_data", bus.out_data, tile);
        chk("capture_busy", 32'(busy), 32'(1));
        chk("capture_no_to", 32'(timeout_err), 32'(0));
        if (rst_hold) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk_reset_vals("rst_hold");
            step();
            chk("rst_hold_conv_rst", 32'(conv_rst), 32'(1));
            return;
        end
        for (int h = 0; h < hw; h++) begin
            bus.out_ready = 1'b0;
            conv_result = rand_tile();
            start = 1'($urandom_range(0, 1));
            kernel_size = KW'(3);
            step();
            chk("hold_valid", 32'(bus.out_valid), 32'(1));
            chk_tile("hold_data", bus.out_data, tile);
            chk("hold_busy", 32'(busy), 32'(1));
        end
        start = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("handshake_valid", 32'(bus.out_valid), 32'(0));
        chk("handshake_busy", 32'(busy), 32'(0));
        chk_tile("handshake_data_kept", bus.out_data, tile);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, dw, hw;
        vecs[0] = '{3,  3, 0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{5,  0, 2, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{0,  0, 0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{6,  0, 0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1,  0, 0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{2, 20, 0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{3,  1, 4, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{4, 15, 1, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{15, 0, 0, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{1,  0, 1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        kernel_size = '0;
        conv_result_ready = 1'b0;
        conv_result = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();
        chk("idle_conv_rst", 32'(conv_rst), 32'(1));
        chk("idle_busy", 32'(busy), 32'(0));

        for (int i = 0; i < 10; i++) begin
            run_tile(vecs[i].k, vecs[i].dw, vecs[i].hw, vecs[i].cfg, vecs[i].to, vecs[i].rh);
        end

        // Reset at FEED step 4 of a K=3 walk, then a fresh K=3 replay.
        start = 1'b1;
        kernel_size = KW'(3);
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 4; i++) step();
        chk("pre_rst_addr", 32'(weight_addr), 32'(4));
        chk("pre_rst_kx", 32'(kx), 32'(1));
        chk("pre_rst_ky", 32'(ky), 32'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("mid_feed_rst");
        step();
        chk("post_rst_conv_rst", 32'(conv_rst), 32'(1));
        run_tile(3, 2, 1, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            k  = int'($urandom_range(0, 7));
            dw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 5));
            hw = int'($urandom_range(0, 5));
            run_tile(k, dw, hw, (k == 0) || (k > int'(KMAX)), dw >= int'(DTO), 1'b0);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                step();
                chk("gap_busy", 32'(busy), 32'(0));
                chk("gap_conv_rst", 32'(conv_rst), 32'(1));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/conv_para_scale_ctrl.md
Name: conv_para_scale_ctrl

Overview:
- Sequencer for the ConvParaScaleFloat16 parallel convolution datapath (PARA_X x PARA_Y float16 output tile, one weight per cycle).
- On start, holds the datapath in reset for one cycle. Then walks the KxK kernel in snake order: one weight address and one window-move code per cycle, so the input buffer presents the matching slice and the weight memory presents the matching weight.
- Waits for the datapath result, captures the tile and hands it downstream over a valid/ready handshake.
- Sits between the layer-level scheduler (start/kernel_size) and the input-buffer, weight-ROM and conv datapath.

Parameters:
PARA_X, 3, tile width in output pixels
PARA_Y, 3, tile height in output pixels
DATA_WIDTH, 16, float16 word width
KERNEL_SIZE_WIDTH, 4, width of kernel_size
KERNEL_MAX, 5, largest legal kernel size
DRAIN_TIMEOUT, 16, max cycles waiting for conv_result_ready

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  request one tile; accepted only in IDLE
kernel_size  in  KERNEL_SIZE_WIDTH  K, sampled when start is accepted
busy  out  1  high in every state except IDLE
cfg_err  out  1  one-cycle pulse: start rejected for illegal K
timeout_err  out  1  one-cycle pulse: drain timeout
conv_rst  out  1  drives the datapath rst (0 = reset datapath, 1 = run)
weight_addr  out  2*KERNEL_SIZE_WIDTH  weight index ky*K+kx
move_code  out  2  0 FULL window, 1 shift RIGHT, 2 shift LEFT, 3 shift DOWN
kx  out  KERNEL_SIZE_WIDTH  current kernel column
ky  out  KERNEL_SIZE_WIDTH  current kernel row
conv_result_ready  in  1  datapath result_ready
conv_result  in  PARA_X*PARA_Y*DATA_WIDTH  datapath result_buffer
out_valid  out  1  captured tile valid
out_ready  in  1  downstream accepts tile
out_data  out  PARA_X*PARA_Y*DATA_WIDTH  captured tile

Behaviour:
- All outputs registered. Reset values: busy=0, cfg_err=0, timeout_err=0, conv_rst=0, weight_addr=0, move_code=0, kx=0, ky=0, out_valid=0, out_data=0.
- States: IDLE, CLEAR, FEED, DRAIN, HOLD.
- IDLE:
  - conv_rst=1.
  - start with 1<=kernel_size<=KERNEL_MAX: latch K, go to CLEAR.
  - start with kernel_size=0 or >KERNEL_MAX: pulse cfg_err, stay in IDLE.
  - start outside IDLE is ignored.
- CLEAR (exactly 1 cycle): conv_rst=0. Next cycle enter FEED with step 0 presented.
- FEED (exactly K*K cycles): conv_rst=1.
  - Step 0: kx=0, ky=0, move_code=FULL.
  - Even ky walks kx upward (RIGHT); odd ky walks kx downward (LEFT).
  - Row change keeps kx and increments ky, move_code=DOWN.
  - weight_addr=ky*K+kx every cycle.
  - After the last step, go to DRAIN.
  - K=1: a single FULL step.
- DRAIN:
  - conv_result_ready=1: capture conv_result into out_data, set out_valid, go to HOLD.
  - No conv_result_ready after DRAIN_TIMEOUT cycles: pulse timeout_err, go to IDLE, no out_valid.
  - conv_result_ready seen during CLEAR/FEED is ignored.
- HOLD:
  - out_data stable while out_valid && !out_ready.
  - out_valid && out_ready: clear out_valid, go to IDLE.
  - Earliest restart: start is accepted in the IDLE cycle immediately following.
- rst mid-operation: next cycle all outputs return to reset values, state IDLE, any captured tile is discarded.
- kernel_size changes after acceptance have no effect until the next start.

Optional Feature:
- Macro CONV_CTRL_PERF_EN.
- Defined:
  - Adds output perf_cycles (32 bit), cleared on rst, counting every cycle busy=1.
  - Adds output perf_stall (32 bit), counting HOLD cycles with out_ready=0.
  - Both saturate at all-ones.
- Undefined: neither port nor counter exists; all other behaviour identical.

Test Plan:
- K=3 start, conv_result_ready asserted 3 cycles after FEED ends, out_ready=1 -> conv_rst low exactly 1 cycle. Then 9 FEED cycles with weight_addr 0,1,2,5,4,3,6,7,8 and move_code FULL,R,R,D,L,L,D,R,R. out_valid 1 cycle with out_data = conv_result.
- K=5 start -> 25 FEED cycles. Row 1 addresses 9,8,7,6,5; final address 20→24 sequence ends at kx=4, ky=4 with move_code RIGHT. busy high from the accept cycle+1 through HOLD exit.
- kernel_size=0, then kernel_size=6 -> cfg_err pulses once per attempt, busy stays 0, conv_rst stays 1.
- conv_result_ready never asserted -> timeout_err pulses exactly DRAIN_TIMEOUT cycles after DRAIN entry, return to IDLE, out_valid never set.
- out_ready held 0 for 4 cycles in HOLD while conv_result changes -> out_data unchanged. start during HOLD ignored. Accepted on the cycle after the handshake.
- rst=1 asserted at FEED step 4 of K=3 -> next cycle all outputs at reset values. A fresh K=3 start then replays the sequence from address 0.
